// File: rtl/multi_bit_sync_filter_if.sv
// Bundle of the level inputs, pulse-mode select and the qualified outputs
// of multi_bit_sync_filter. master = the logic feeding/observing the filter,
// slave = the filter itself.
interface multi_bit_sync_filter_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] async;
    logic [1:0]        edge_mode;
    logic [NUM_CH-1:0] sync;
    logic [NUM_CH-1:0] pulse;
    logic              any_pulse;

    modport master (
        output async,
        output edge_mode,
        input  sync,
        input  pulse,
        input  any_pulse
    );

    modport slave (
        input  async,
        input  edge_mode,
        output sync,
        output pulse,
        output any_pulse
    );
endinterface

// File: rtl/multi_bit_sync_filter.sv
// Multi-channel level synchronizer with glitch filter and edge-pulse output.
// Each channel: NUM_STAGES flop chain -> FILT_LEN-cycle stability filter ->
// registered level (sync) plus a one-cycle pulse on accepted edges selected
// by edge_mode (bit0 = rising, bit1 = falling).
module multi_bit_sync_filter #(
    parameter int                NUM_CH     = 4,
    parameter int                NUM_STAGES = 2,
    parameter int                FILT_LEN   = 4,
    parameter logic [NUM_CH-1:0] RST_VAL    = '0
) (
    input  logic                  clk,
    input  logic                  rst,   // asynchronous, active-low
    multi_bit_sync_filter_if.slave bus
);
    localparam int CNT_W = ($clog2(FILT_LEN + 1) < 1) ? 1 : $clog2(FILT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

    logic [NUM_CH-1:0]            meta_p0 [NUM_STAGES];
    logic [NUM_CH-1:0]            raw;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_p1;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_nxt;
    logic [NUM_CH-1:0]            lvl_p1;
    logic [NUM_CH-1:0]            lvl_nxt;
    logic [NUM_CH-1:0]            pulse_p1;
    logic [NUM_CH-1:0]            pulse_nxt;
    logic                         any_pulse_p1;

    // Stage 0: plain flop chain per channel, no logic between stages.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                meta_p0[s] <= RST_VAL;
            end
        end else begin
            meta_p0[0] <= bus.async;
            for (int s = 1; s < NUM_STAGES; s++) begin
                meta_p0[s] <= meta_p0[s-1];
            end
        end
    end

    assign raw = meta_p0[NUM_STAGES-1];

    // Filter and edge qualification: a new level is taken only after it has
    // differed from the current level on FILT_LEN consecutive edges; any
    // return to the current level restarts the count.
    always_comb begin
        lvl_nxt   = lvl_p1;
        pulse_nxt = '0;
        cnt_nxt   = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (raw[ch] != lvl_p1[ch]) begin
                if (cnt_p1[ch] == CNT_MAX) begin
                    lvl_nxt[ch]   = raw[ch];
                    pulse_nxt[ch] = (raw[ch] & bus.edge_mode[0]) |
                                    (~raw[ch] & bus.edge_mode[1]);
                end else begin
                    cnt_nxt[ch] = cnt_p1[ch] + CNT_W'(1);
                end
            end
        end
    end

    // Stage 1: filter counters, accepted level and pulse outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_p1       <= '0;
            lvl_p1       <= RST_VAL;
            pulse_p1     <= '0;
            any_pulse_p1 <= 1'b0;
        end else begin
            cnt_p1       <= cnt_nxt;
            lvl_p1       <= lvl_nxt;
            pulse_p1     <= pulse_nxt;
            any_pulse_p1 <= |pulse_nxt;
        end
    end

    assign bus.sync      = lvl_p1;
    assign bus.pulse     = pulse_p1;
    assign bus.any_pulse = any_pulse_p1;

endmodule

// File: tb/tb_multi_bit_sync_filter.sv
// Bench for multi_bit_sync_filter: three instances (defaults; 8 ch / 3 stages /
// no filtering; non-zero reset value) driven by scenario tasks, plus a random
// soak of the third instance against a window-based reference model.
module tb_multi_bit_sync_filter;
    localparam logic [3:0] U2_RV = 4'b0101;
    localparam int         U2_NS = 2;
    localparam int         U2_FL = 4;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   u2_spurious;
    bit   soak_on;

    multi_bit_sync_filter_if #(.NUM_CH(4)) bus0 ();
    multi_bit_sync_filter_if #(.NUM_CH(8)) bus1 ();
    multi_bit_sync_filter_if #(.NUM_CH(4)) bus2 ();

    multi_bit_sync_filter #(.NUM_CH(4), .NUM_STAGES(2), .FILT_LEN(4), .RST_VAL(4'b0000))
        u0 (.clk(clk), .rst(rst), .bus(bus0));
    multi_bit_sync_filter #(.NUM_CH(8), .NUM_STAGES(3), .FILT_LEN(1), .RST_VAL(8'h00))
        u1 (.clk(clk), .rst(rst), .bus(bus1));
    multi_bit_sync_filter #(.NUM_CH(4), .NUM_STAGES(U2_NS), .FILT_LEN(U2_FL), .RST_VAL(U2_RV))
        u2 (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference for u2: level v is accepted at edge k when the raw value seen
    // on the last FILT_LEN edges was v throughout, v differs from the current
    // level, and that whole window lies after the previous acceptance/reset.
    logic [3:0] m_hist[$];
    int         m_k;
    int         m_last[4];
    logic [3:0] m_sync;
    logic [3:0] m_pulse;
    logic       m_any;

    function automatic logic raw_at(int k, int ch);
        int j;
        j = k - U2_NS;
        if (j < 1) return U2_RV[ch];
        return m_hist[j-1][ch];
    endfunction

    always @(posedge clk or negedge rst) begin
        logic [3:0] np;
        logic       v;
        bit         ok;
        if (!rst) begin
            m_hist.delete();
            m_k     = 0;
            m_sync  = U2_RV;
            m_pulse = '0;
            m_any   = 1'b0;
            for (int c = 0; c < 4; c++) m_last[c] = 0;
        end else begin
            m_k++;
            m_hist.push_back(bus2.async);
            np = '0;
            for (int c = 0; c < 4; c++) begin
                v  = raw_at(m_k, c);
                ok = (v != m_sync[c]) && (m_k - m_last[c] >= U2_FL);
                for (int i = 1; i < U2_FL; i++) begin
                    if (raw_at(m_k - i, c) != v) ok = 0;
                end
                if (ok) begin
                    m_sync[c] = v;
                    m_last[c] = m_k;
                    np[c]     = v ? bus2.edge_mode[0] : bus2.edge_mode[1];
                end
            end
            m_pulse = np;
            m_any   = |np;
        end
    end

    // u2 input sits at its reset value until the soak, so it must stay silent.
    always @(negedge clk) begin
        if (!soak_on && (bus2.pulse != '0 || bus2.any_pulse)) u2_spurious++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        n_tests++;
        if ({bus0.sync, bus0.pulse, bus0.any_pulse} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_u0 got %b/%b/%b want 0000/0000/0", bus0.sync, bus0.pulse, bus0.any_pulse);
        end
        n_tests++;
        if ({bus1.sync, bus1.pulse, bus1.any_pulse} !== 17'b0) begin
            n_fail++;
            $display("FAIL reset_u1 got %h/%h/%b want 00/00/0", bus1.sync, bus1.pulse, bus1.any_pulse);
        end
        n_tests++;
        if ({bus2.sync, bus2.pulse, bus2.any_pulse} !== {U2_RV, 4'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_u2 got %b/%b/%b want %b/0000/0", bus2.sync, bus2.pulse, bus2.any_pulse, U2_RV);
        end
        rst = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_rise();
        logic [3:0] es, ep;
        bus0.edge_mode = 2'b01;
        bus0.async     = 4'b0001;
        for (int e = 1; e <= 8; e++) begin
            tick();
            es = (e >= 6) ? 4'b0001 : 4'b0000;
            ep = (e == 6) ? 4'b0001 : 4'b0000;
            n_tests++;
            if ({bus0.sync, bus0.pulse, bus0.any_pulse} !== {es, ep, |ep}) begin
                n_fail++;
                $display("FAIL rise e=%0d got %b/%b/%b want %b/%b/%b", e,
                         bus0.sync, bus0.pulse, bus0.any_pulse, es, ep, |ep);
            end
        end
        bus0.async = 4'b0000;
        for (int e = 1; e <= 8; e++) begin
            tick();
            es = (e >= 6) ? 4'b0000 : 4'b0001;
            n_tests++;
            if ({bus0.sync, bus0.pulse, bus0.any_pulse} !== {es, 4'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL fall_mode01 e=%0d got %b/%b/%b want %b/0000/0", e,
                         bus0.sync, bus0.pulse, bus0.any_pulse, es);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] es, ep;
        bus0.edge_mode = 2'b11;
        bus0.async     = 4'b0010;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 3) bus0.async = 4'b0000;
            n_tests++;
            if ({bus0.sync, bus0.pulse, bus0.any_pulse} !== 9'b0) begin
                n_fail++;
                $display("FAIL glitch3 e=%0d got %b/%b/%b want 0000/0000/0", e,
                         bus0.sync, bus0.pulse, bus0.any_pulse);
            end
        end
        bus0.async = 4'b0010;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (e == 5) bus0.async = 4'b0000;
            es = (e >= 6 && e < 11) ? 4'b0010 : 4'b0000;
            ep = (e == 6 || e == 11) ? 4'b0010 : 4'b0000;
            n_tests++;
            if ({bus0.sync, bus0.pulse, bus0.any_pulse} !== {es, ep, |ep}) begin
                n_fail++;
                $display("FAIL pulse5 e=%0d got %b/%b/%b want %b/%b/%b", e,
                         bus0.sync, bus0.pulse, bus0.any_pulse, es, ep, |ep);
            end
        end
    endtask

    task automatic test_all_fall();
        logic [3:0] ph_in [4] = '{4'hF, 4'h0, 4'hF, 4'h0};
        logic [1:0] ph_em [4] = '{2'b10, 2'b10, 2'b00, 2'b00};
        logic [3:0] ph_p  [4] = '{4'h0, 4'hF, 4'h0, 4'h0};
        logic [3:0] old, es, ep;
        old = 4'h0;
        for (int p = 0; p < 4; p++) begin
            bus0.edge_mode = ph_em[p];
            bus0.async     = ph_in[p];
            for (int e = 1; e <= 8; e++) begin
                tick();
                es = (e >= 6) ? ph_in[p] : old;
                ep = (e == 6) ? ph_p[p] : 4'h0;
                n_tests++;
                if ({bus0.sync, bus0.pulse, bus0.any_pulse} !== {es, ep, |ep}) begin
                    n_fail++;
                    $display("FAIL all_ch ph=%0d e=%0d got %b/%b/%b want %b/%b/%b", p, e,
                             bus0.sync, bus0.pulse, bus0.any_pulse, es, ep, |ep);
                end
            end
            old = ph_in[p];
        end
    endtask

    task automatic test_fast_chain();
        logic [7:0] old, nv, es, ep;
        logic [1:0] em;
        old = 8'h00;
        for (int it = 0; it < 12; it++) begin
            nv = 8'($urandom);
            em = 2'($urandom_range(0, 3));
            bus1.edge_mode = em;
            bus1.async     = nv;
            for (int e = 1; e <= 5; e++) begin
                tick();
                es = (e >= 4) ? nv : old;
                ep = (e == 4) ? (((nv & ~old) & {8{em[0]}}) | ((~nv & old) & {8{em[1]}})) : 8'h00;
                n_tests++;
                if ({bus1.sync, bus1.pulse, bus1.any_pulse} !== {es, ep, |ep}) begin
                    n_fail++;
                    $display("FAIL fast it=%0d e=%0d got %h/%h/%b want %h/%h/%b", it, e,
                             bus1.sync, bus1.pulse, bus1.any_pulse, es, ep, |ep);
                end
            end
            old = nv;
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] es, ep;
        bus0.edge_mode = 2'b01;
        bus0.async     = 4'b0000;
        repeat (8) tick();
        bus0.async = 4'b0001;
        repeat (2) tick();
        bus0.async = 4'b0101;
        repeat (4) tick();
        n_tests++;
        if ({bus0.sync, bus0.pulse, bus0.any_pulse} !== {4'b0001, 4'b0001, 1'b1}) begin
            n_fail++;
            $display("FAIL pre_reset got %b/%b/%b want 0001/0001/1", bus0.sync, bus0.pulse, bus0.any_pulse);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({bus0.sync, bus0.pulse, bus0.any_pulse} !== 9'b0) begin
            n_fail++;
            $display("FAIL async_reset got %b/%b/%b want 0000/0000/0", bus0.sync, bus0.pulse, bus0.any_pulse);
        end
        repeat (2) tick();
        n_tests++;
        if ({bus0.sync, bus0.pulse, bus0.any_pulse} !== 9'b0) begin
            n_fail++;
            $display("FAIL held_reset got %b/%b/%b want 0000/0000/0", bus0.sync, bus0.pulse, bus0.any_pulse);
        end
        rst = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            es = (e >= 6) ? 4'b0101 : 4'b0000;
            ep = (e == 6) ? 4'b0101 : 4'b0000;
            n_tests++;
            if ({bus0.sync, bus0.pulse, bus0.any_pulse} !== {es, ep, |ep}) begin
                n_fail++;
                $display("FAIL post_reset e=%0d got %b/%b/%b want %b/%b/%b", e,
                         bus0.sync, bus0.pulse, bus0.any_pulse, es, ep, |ep);
            end
        end
    endtask

    task automatic test_rst_val_soak();
        int hold;
        int bad;
        n_tests++;
        if (u2_spurious != 0) begin
            n_fail++;
            $display("FAIL rstval_quiet pulses_seen=%0d want 0", u2_spurious);
        end
        n_tests++;
        if (bus2.sync !== U2_RV) begin
            n_fail++;
            $display("FAIL rstval_level got %b want %b", bus2.sync, U2_RV);
        end
        soak_on = 1'b1;
        hold    = 0;
        bad     = 0;
        for (int c = 0; c < 600; c++) begin
            if (hold == 0) begin
                bus2.async     = 4'($urandom);
                bus2.edge_mode = 2'($urandom_range(0, 3));
                hold           = $urandom_range(1, 8);
            end
            hold--;
            tick();
            n_tests++;
            if ({bus2.sync, bus2.pulse, bus2.any_pulse} !== {m_sync, m_pulse, m_any}) begin
                n_fail++;
                if (bad < 10)
                    $display("FAIL soak c=%0d got %b/%b/%b want %b/%b/%b", c,
                             bus2.sync, bus2.pulse, bus2.any_pulse, m_sync, m_pulse, m_any);
                bad++;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        u2_spurious    = 0;
        soak_on        = 1'b0;
        rst            = 1'b0;
        bus0.async     = 4'b0000;
        bus0.edge_mode = 2'b00;
        bus1.async     = 8'h00;
        bus1.edge_mode = 2'b00;
        bus2.async     = U2_RV;
        bus2.edge_mode = 2'b11;
        test_reset();
        test_rise();
        test_glitch();
        test_all_fall();
        test_fast_chain();
        test_reset_mid();
        test_rst_val_soak();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
